// File: rtl/controller_pkg.sv
// Shared types and constants for the multicycle controller: opcodes, FSM states,
// ALUOp bit positions and the decoded control bundle.
package controller_pkg;

  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpLw    = 7'b0000011;
  localparam logic [6:0] OpSw    = 7'b0100011;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpOpImm = 7'b0010011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpHalti = 7'b1000000;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_t;

  localparam int unsigned AluOpBrJmpBit  = 0;
  localparam int unsigned AluOpRegJmpBit = 1;
  localparam int unsigned AluOpMemJmpBit = 2;

  typedef struct packed {
    logic       alu_src;
    logic [2:0] alu_op;
    logic       curr_flag;
    logic       is_r;
    logic       is_lw;
    logic       is_sw;
    logic       is_br;
    logic       is_opimm;
    logic       is_jal;
    logic       is_jalr;
    logic       is_halt;
    logic       legal;
  } ctrl_t;

endpackage

// File: rtl/main_decoder.sv
// Combinational opcode decoder producing the datapath control bundle and class flags.
module main_decoder
  import controller_pkg::*;
(
  input  logic [6:0] op_i,
  output ctrl_t      ctrl_o
);

  logic is_r, is_lw, is_sw, is_br, is_opimm, is_jal, is_jalr, is_halt;

  assign is_r     = (op_i == OpR);
  assign is_lw    = (op_i == OpLw);
  assign is_sw    = (op_i == OpSw);
  assign is_br    = (op_i == OpBr);
  assign is_opimm = (op_i == OpOpImm);
  assign is_jal   = (op_i == OpJal);
  assign is_jalr  = (op_i == OpJalr);
  assign is_halt  = (op_i == OpHalti);

  always_comb begin
    ctrl_o                         = '0;
    ctrl_o.is_r                    = is_r;
    ctrl_o.is_lw                   = is_lw;
    ctrl_o.is_sw                   = is_sw;
    ctrl_o.is_br                   = is_br;
    ctrl_o.is_opimm                = is_opimm;
    ctrl_o.is_jal                  = is_jal;
    ctrl_o.is_jalr                 = is_jalr;
    ctrl_o.is_halt                 = is_halt;
    ctrl_o.legal                   = is_r | is_lw | is_sw | is_br | is_opimm | is_jal | is_jalr |
                                     is_halt;
    ctrl_o.alu_src                 = is_lw | is_sw | is_opimm | is_jal | is_jalr;
    ctrl_o.alu_op[AluOpBrJmpBit]   = is_br | is_jal | is_jalr;
    ctrl_o.alu_op[AluOpRegJmpBit]  = is_r | is_jal | is_jalr;
    ctrl_o.alu_op[AluOpMemJmpBit]  = is_lw | is_sw | is_jal | is_jalr;
    ctrl_o.curr_flag               = is_jalr;
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: fetch/decode/exec/mem/wb with bounded memory waits,
// sticky illegal-opcode and timeout flags, and an absorbing halt state.
module multicycle_controller
  import controller_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned ALUOP_W  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         Opcode,
  input  logic               ImemReady,
  input  logic               DmemReady,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               ALUSrc,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               Branch,
  output logic               Jump,
  output logic               CurrFlag,
  output logic               halt,
  output logic               Illegal,
  output logic               Timeout,
  output logic [2:0]         State
);

  localparam int unsigned CntW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

  state_t          state_q;
  logic [6:0]      op_q;
  logic [CntW-1:0] cnt_q;
  logic            illegal_q;
  logic            timeout_q;

  logic [6:0] dec_op;
  ctrl_t      dec;
  logic       wait_state;
  logic       ready;
  logic       wait_expired;

  // In DECODE the op register is still being loaded, so decode the live opcode.
  assign dec_op = (state_q == StDecode) ? Opcode : op_q;

  main_decoder u_main_decoder (
    .op_i   (dec_op),
    .ctrl_o (dec)
  );

  assign wait_state   = (state_q == StFetch) || (state_q == StMem);
  assign ready        = (state_q == StFetch) ? ImemReady : DmemReady;
  assign wait_expired = (WAIT_MAX > 0) && wait_state && !ready && (cnt_q == LastCnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      op_q      <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q <= (wait_state && !ready) ? cnt_q + CntW'(1) : '0;
      case (state_q)
        StFetch: begin
          if (ImemReady) begin
            state_q <= StDecode;
          end else if (wait_expired) begin
            timeout_q <= 1'b1;
            state_q   <= StHalt;
          end
        end
        StDecode: begin
          op_q <= Opcode;
          if (dec.is_halt) begin
            state_q <= StHalt;
          end else if (!dec.legal) begin
            illegal_q <= 1'b1;
            state_q   <= StFetch;
          end else begin
            state_q <= StExec;
          end
        end
        StExec: begin
          if (dec.is_lw || dec.is_sw) begin
            state_q <= StMem;
          end else if (dec.is_r || dec.is_opimm || dec.is_jal || dec.is_jalr) begin
            state_q <= StWb;
          end else begin
            state_q <= StFetch;
          end
        end
        StMem: begin
          if (DmemReady) begin
            state_q <= dec.is_lw ? StWb : StFetch;
          end else if (wait_expired) begin
            timeout_q <= 1'b1;
            state_q   <= StHalt;
          end
        end
        StWb:    state_q <= StFetch;
        StHalt:  state_q <= StHalt;
        default: state_q <= StHalt;
      endcase
    end
  end

  // Outputs are forced low during reset, even though state only clears at the edge.
  always_comb begin
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    ALUOp    = '0;
    Branch   = 1'b0;
    Jump     = 1'b0;
    CurrFlag = 1'b0;
    halt     = 1'b0;
    Illegal  = 1'b0;
    Timeout  = 1'b0;
    State    = 3'd0;
    if (!reset) begin
      State   = state_q;
      Illegal = illegal_q;
      Timeout = timeout_q;
      case (state_q)
        StFetch: begin
          IRWrite = ImemReady;
          PCWrite = ImemReady;
        end
        StExec: begin
          Branch = dec.is_br;
          Jump   = dec.is_jal | dec.is_jalr;
        end
        StMem: begin
          MemRead  = dec.is_lw;
          MemWrite = dec.is_sw;
        end
        StWb: begin
          RegWrite = 1'b1;
          MemtoReg = dec.is_lw;
        end
        StHalt:  halt = 1'b1;
        default: ;
      endcase
      if (state_q == StExec || state_q == StMem || state_q == StWb) begin
        ALUSrc   = dec.alu_src;
        ALUOp    = ALUOP_W'(dec.alu_op);
        CurrFlag = dec.curr_flag;
      end
    end
  end

endmodule
